rv32i_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I core. Decodes the latched instruction and sequences fetch, execute, memory and writeback.
- Drives the datapath muxes, register/PC/IR write enables and the 4-bit ALU select. It is the producer side of the ALU select interface.
- Handshakes with instruction and data memories via req/ack.
- Supported subset: R-type ALU, I-type ALU, LW, SW, BEQ/BNE, JAL, LUI. Everything else traps.

---
 rtl/rv32i_multicycle_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_rv32i_multicycle_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: decodes the latched instruction and sequences
// fetch / decode / execute / memory / writeback, driving datapath selects and enables.
module rv32i_multicycle_ctrl #(
    parameter bit RESET_TRAP_CLR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        alu_zero,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        reg_we,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_sel,
    output logic [2:0]  imm_sel,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STOR = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    state_t      state_q, state_d;
    logic        illegal_q, illegal_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        r_ok, i_ok;
    logic        unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    always_comb begin
        r_ok = 1'b0;
        i_ok = 1'b0;
        if (funct7 == 7'b0000000)
            r_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
        else if (funct7 == 7'b0100000)
            r_ok = (funct3 == 3'b000) || (funct3 == 3'b101);
        case (funct3)
            3'b010, 3'b011: i_ok = 1'b0;
            3'b001:         i_ok = (funct7 == 7'b0000000);
            3'b101:         i_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            default:        i_ok = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_TRAP;
                case (opcode)
                    OP_R:    if (r_ok) state_d = S_EXEC_R;
                    OP_I:    if (i_ok) state_d = S_EXEC_I;
                    OP_LOAD, OP_STOR: if (funct3 == 3'b010) state_d = S_MEM_ADDR;
                    OP_BR:   if (funct3 == 3'b000 || funct3 == 3'b001) state_d = S_BRANCH;
                    OP_JAL:  state_d = S_JAL;
                    OP_LUI:  state_d = S_LUI;
                    default: state_d = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_MEM_ADDR: state_d = (opcode == OP_STOR) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (dmem_ack) state_d = S_MEM_WB;
            S_MEM_WR: if (dmem_ack) state_d = S_FETCH;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_LUI: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    // Debug builds may keep the trap flag across reset to inspect post-mortem.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            if (RESET_TRAP_CLR) illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    logic       imem_req_m, dmem_req_m, dmem_we_m, ir_we_m, pc_we_m, pc_src_m, reg_we_m;
    logic [1:0] src_a_m, src_b_m, wb_sel_m;
    logic [3:0] alu_sel_m;
    logic [2:0] imm_sel_m;

    always_comb begin
        imem_req_m = 1'b0;
        dmem_req_m = 1'b0;
        dmem_we_m  = 1'b0;
        ir_we_m    = 1'b0;
        pc_we_m    = 1'b0;
        pc_src_m   = 1'b0;
        reg_we_m   = 1'b0;
        src_a_m    = 2'b00;
        src_b_m    = 2'b00;
        alu_sel_m  = 4'b0000;
        imm_sel_m  = 3'b000;
        wb_sel_m   = 2'b00;
        case (state_q)
            S_FETCH: begin
                imem_req_m = 1'b1;
                src_a_m    = 2'b01;
                src_b_m    = 2'b10;
                ir_we_m    = imem_ack;
                pc_we_m    = imem_ack;
            end
            S_DECODE: begin
                src_a_m = 2'b10;
                src_b_m = 2'b01;
                case (opcode)
                    OP_STOR: imm_sel_m = 3'b001;
                    OP_BR:   imm_sel_m = 3'b010;
                    OP_JAL:  imm_sel_m = 3'b011;
                    OP_LUI:  imm_sel_m = 3'b100;
                    default: imm_sel_m = 3'b000;
                endcase
            end
            S_EXEC_R: alu_sel_m = {funct7[5], funct3};
            S_EXEC_I: begin
                src_b_m   = 2'b01;
                alu_sel_m = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
            end
            S_ALU_WB: reg_we_m = 1'b1;
            S_MEM_ADDR: begin
                src_b_m   = 2'b01;
                imm_sel_m = (opcode == OP_STOR) ? 3'b001 : 3'b000;
            end
            S_MEM_RD: dmem_req_m = 1'b1;
            S_MEM_WB: begin
                reg_we_m = 1'b1;
                wb_sel_m = 2'b01;
            end
            S_MEM_WR: begin
                dmem_req_m = 1'b1;
                dmem_we_m  = 1'b1;
            end
            S_BRANCH: begin
                alu_sel_m = 4'b1000;
                pc_src_m  = 1'b1;
                pc_we_m   = funct3[0] ? ~alu_zero : alu_zero;
            end
            S_JAL: begin
                imm_sel_m = 3'b011;
                src_a_m   = 2'b10;
                src_b_m   = 2'b10;
                wb_sel_m  = 2'b10;
                reg_we_m  = 1'b1;
                pc_src_m  = 1'b1;
                pc_we_m   = 1'b1;
            end
            S_LUI: begin
                imm_sel_m = 3'b100;
                src_a_m   = 2'b11;
                src_b_m   = 2'b01;
                reg_we_m  = 1'b1;
                wb_sel_m  = 2'b10;
            end
            default: ;
        endcase
    end

    // rst_n gates every output so enables drop the instant reset asserts, mid-handshake included.
    assign imem_req  = rst_n & imem_req_m;
    assign dmem_req  = rst_n & dmem_req_m;
    assign dmem_we   = rst_n & dmem_we_m;
    assign ir_we     = rst_n & ir_we_m;
    assign pc_we     = rst_n & pc_we_m;
    assign pc_src    = rst_n & pc_src_m;
    assign reg_we    = rst_n & reg_we_m;
    assign alu_src_a = rst_n ? src_a_m   : 2'b00;
    assign alu_src_b = rst_n ? src_b_m   : 2'b00;
    assign alu_sel   = rst_n ? alu_sel_m : 4'b0000;
    assign imm_sel   = rst_n ? imm_sel_m : 3'b000;
    assign wb_sel    = rst_n ? wb_sel_m  : 2'b00;
    assign illegal   = illegal_q;
    assign state     = state_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Directed bench for rv32i_multicycle_ctrl: walks each instruction class through its
// state sequence and compares a snapshot of every output against hand-derived values.
module tb_rv32i_multicycle_ctrl;

    logic        clk, rst_n;
    logic [31:0] instr;
    logic        imem_ack, dmem_ack, alu_zero;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we;
    logic [1:0]  alu_src_a, alu_src_b, wb_sel;
    logic [3:0]  alu_sel, state;
    logic [2:0]  imm_sel;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;
    logic [24:0] exp_v;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_EXEC_R = 4'd2,
        ST_EXEC_I = 4'd3, ST_ALU_WB = 4'd4, ST_MEM_ADDR = 4'd5, ST_MEM_RD = 4'd6,
        ST_MEM_WB = 4'd7, ST_MEM_WR = 4'd8, ST_BRANCH = 4'd9, ST_JAL = 4'd10,
        ST_LUI = 4'd11, ST_TRAP = 4'd12;

    rv32i_multicycle_ctrl #(.RESET_TRAP_CLR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ack(imem_ack),
        .dmem_ack(dmem_ack), .alu_zero(alu_zero), .imem_req(imem_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .reg_we(reg_we), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_sel(alu_sel), .imm_sel(imm_sel),
        .wb_sel(wb_sel), .illegal(illegal), .state(state)
    );

    // Enable order: imem_req dmem_req dmem_we ir_we pc_we pc_src reg_we
    logic [24:0] obs;
    assign obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we,
                  alu_src_a, alu_src_b, alu_sel, imm_sel, wb_sel, illegal, state};

    function automatic logic [24:0] pk(input logic [6:0] en, input logic [1:0] a,
                                       input logic [1:0] b, input logic [3:0] sel,
                                       input logic [2:0] imm, input logic [1:0] wb,
                                       input logic ill, input logic [3:0] st);
        return {en, a, b, sel, imm, wb, ill, st};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_instr(input logic [31:0] ins);
        instr    = ins;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        exp_v = pk(7'b0, 2'b00, 2'b00, 4'h0, 3'b000, 2'b00, 1'b0, ST_FETCH);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_hold: got %h want %h", obs, exp_v); end
        rst_n = 1'b1;
        #1;
        exp_v = pk(7'b1000000, 2'b01, 2'b10, 4'h0, 3'b000, 2'b00, 1'b0, ST_FETCH);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_release_fetch: got %h want %h", obs, exp_v); end
        step();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL fetch_wait: got %h want %h", obs, exp_v); end
        rst_n = 1'b0;
        #1;
        exp_v = pk(7'b0, 2'b00, 2'b00, 4'h0, 3'b000, 2'b00, 1'b0, ST_FETCH);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_in_fetch: got %h want %h", obs, exp_v); end
        rst_n = 1'b1;
        #1;
        fetch_instr(32'h0040A183);
        step();
        step();
        exp_v = pk(7'b0100000, 2'b00, 2'b00, 4'h0, 3'b000, 2'b00, 1'b0, ST_MEM_RD);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL pre_reset_mem_rd: got %h want %h", obs, exp_v); end
        rst_n = 1'b0;
        #1;
        exp_v = pk(7'b0, 2'b00, 2'b00, 4'h0, 3'b000, 2'b00, 1'b0, ST_FETCH);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_mid_dmem: got %h want %h", obs, exp_v); end
        rst_n = 1'b1;
        #1;
        exp_v = pk(7'b1000000, 2'b01, 2'b10, 4'h0, 3'b000, 2'b00, 1'b0, ST_FETCH);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL refetch_after_reset: got %h want %h", obs, exp_v); end
        step();
    endtask

    task automatic test_r_type();
        instr    = 32'h40315233;
        imem_ack = 1'b1;
        #1;
        exp_v = pk(7'b1001100, 2'b01, 2'b10, 4'h0, 3'b000, 2'b00, 1'b0, ST_FETCH);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sra_fetch_ack: got %h want %h", obs, exp_v); end
        step();
        imem_ack = 1'b0;
        exp_v = pk(7'b0, 2'b10, 2'b01, 4'h0, 3'b000, 2'b00, 1'b0, ST_DECODE);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sra_decode: got %h want %h", obs, exp_v); end
        step();
        imem_ack = 1'b1;
        #1;
        exp_v = pk(7'b0, 2'b00, 2'b00, 4'b1101, 3'b000, 2'b00, 1'b0, ST_EXEC_R);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sra_exec_r: got %h want %h", obs, exp_v); end
        imem_ack = 1'b0;
        step();
        exp_v = pk(7'b0000001, 2'b00, 2'b00, 4'h0, 3'b000, 2'b00, 1'b0, ST_ALU_WB);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sra_alu_wb: got %h want %h", obs, exp_v); end
        step();
        exp_v = pk(7'b1000000, 2'b01, 2'b10, 4'h0, 3'b000, 2'b00, 1'b0, ST_FETCH);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sra_back_to_fetch: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_load();
        fetch_instr(32'h0040A183);
        step();
        exp_v = pk(7'b0, 2'b00, 2'b01, 4'h0, 3'b000, 2'b00, 1'b0, ST_MEM_ADDR);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lw_mem_addr: got %h want %h", obs, exp_v); end
        step();
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            #1;
            exp_v = pk(7'b0100000, 2'b00, 2'b00, 4'h0, 3'b000, 2'b00, 1'b0, ST_MEM_RD);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL lw_mem_rd_cycle%0d: got %h want %h", i, obs, exp_v); end
            step();
        end
        dmem_ack = 1'b0;
        exp_v = pk(7'b0000001, 2'b00, 2'b00, 4'h0, 3'b000, 2'b01, 1'b0, ST_MEM_WB);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lw_mem_wb: got %h want %h", obs, exp_v); end
        step();
        exp_v = pk(7'b1000000, 2'b01, 2'b10, 4'h0, 3'b000, 2'b00, 1'b0, ST_FETCH);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lw_back_to_fetch: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_store();
        fetch_instr(32'h0020A223);
        exp_v = pk(7'b0, 2'b10, 2'b01, 4'h0, 3'b001, 2'b00, 1'b0, ST_DECODE);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sw_decode: got %h want %h", obs, exp_v); end
        step();
        exp_v = pk(7'b0, 2'b00, 2'b01, 4'h0, 3'b001, 2'b00, 1'b0, ST_MEM_ADDR);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sw_mem_addr: got %h want %h", obs, exp_v); end
        step();
        dmem_ack = 1'b1;
        #1;
        exp_v = pk(7'b0110000, 2'b00, 2'b00, 4'h0, 3'b000, 2'b00, 1'b0, ST_MEM_WR);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sw_mem_wr: got %h want %h", obs, exp_v); end
        step();
        dmem_ack = 1'b0;
        exp_v = pk(7'b1000000, 2'b01, 2'b10, 4'h0, 3'b000, 2'b00, 1'b0, ST_FETCH);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sw_back_to_fetch: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_branch();
        logic [31:0] ins [4];
        logic        zin [4];
        logic        we  [4];
        ins = '{32'h00208463, 32'h00208463, 32'h00209463, 32'h00209463};
        zin = '{1'b1, 1'b0, 1'b1, 1'b0};
        we  = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            fetch_instr(ins[k]);
            exp_v = pk(7'b0, 2'b10, 2'b01, 4'h0, 3'b010, 2'b00, 1'b0, ST_DECODE);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL br%0d_decode: got %h want %h", k, obs, exp_v); end
            step();
            alu_zero = zin[k];
            #1;
            exp_v = pk({4'b0000, we[k], 2'b10}, 2'b00, 2'b00, 4'b1000, 3'b000, 2'b00, 1'b0, ST_BRANCH);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL br%0d_branch: got %h want %h", k, obs, exp_v); end
            step();
            alu_zero = 1'b0;
            exp_v = pk(7'b1000000, 2'b01, 2'b10, 4'h0, 3'b000, 2'b00, 1'b0, ST_FETCH);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL br%0d_fetch: got %h want %h", k, obs, exp_v); end
        end
    endtask

    task automatic test_jal_lui();
        fetch_instr(32'h008000EF);
        exp_v = pk(7'b0, 2'b10, 2'b01, 4'h0, 3'b011, 2'b00, 1'b0, ST_DECODE);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL jal_decode: got %h want %h", obs, exp_v); end
        step();
        exp_v = pk(7'b0000111, 2'b10, 2'b10, 4'h0, 3'b011, 2'b10, 1'b0, ST_JAL);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL jal_exec: got %h want %h", obs, exp_v); end
        step();
        exp_v = pk(7'b1000000, 2'b01, 2'b10, 4'h0, 3'b000, 2'b00, 1'b0, ST_FETCH);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL jal_fetch: got %h want %h", obs, exp_v); end
        fetch_instr(32'h123452B7);
        exp_v = pk(7'b0, 2'b10, 2'b01, 4'h0, 3'b100, 2'b00, 1'b0, ST_DECODE);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lui_decode: got %h want %h", obs, exp_v); end
        step();
        exp_v = pk(7'b0000001, 2'b11, 2'b01, 4'h0, 3'b100, 2'b10, 1'b0, ST_LUI);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lui_exec: got %h want %h", obs, exp_v); end
        step();
        exp_v = pk(7'b1000000, 2'b01, 2'b10, 4'h0, 3'b000, 2'b00, 1'b0, ST_FETCH);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL lui_fetch: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_i_type();
        logic [31:0] ins [3];
        logic [3:0]  sel [3];
        ins = '{32'h4030D113, 32'h0030D113, 32'h00508093};
        sel = '{4'b1101, 4'b0101, 4'b0000};
        for (int k = 0; k < 3; k++) begin
            fetch_instr(ins[k]);
            step();
            exp_v = pk(7'b0, 2'b00, 2'b01, sel[k], 3'b000, 2'b00, 1'b0, ST_EXEC_I);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL itype%0d_exec_i: got %h want %h", k, obs, exp_v); end
            step();
            exp_v = pk(7'b0000001, 2'b00, 2'b00, 4'h0, 3'b000, 2'b00, 1'b0, ST_ALU_WB);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL itype%0d_alu_wb: got %h want %h", k, obs, exp_v); end
            step();
        end
    endtask

    task automatic test_traps();
        logic [31:0] ins [6];
        ins = '{32'h0010A113, 32'h40109113, 32'h0020A233, 32'h00000073,
                32'h00409183, 32'h40209233};
        for (int k = 0; k < 6; k++) begin
            fetch_instr(ins[k]);
            step();
            exp_v = pk(7'b0, 2'b00, 2'b00, 4'h0, 3'b000, 2'b00, 1'b1, ST_TRAP);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL trap%0d_enter: got %h want %h", k, obs, exp_v); end
            if (k == 0) begin
                imem_ack = 1'b1;
                dmem_ack = 1'b1;
                for (int c = 0; c < 20; c++) begin
                    step();
                    n_cmp++;
                    if (obs !== exp_v) begin n_err++; $display("FAIL trap_hold_c%0d: got %h want %h", c, obs, exp_v); end
                end
                imem_ack = 1'b0;
                dmem_ack = 1'b0;
            end
            rst_n = 1'b0;
            #1;
            exp_v = pk(7'b0, 2'b00, 2'b00, 4'h0, 3'b000, 2'b00, 1'b0, ST_FETCH);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL trap%0d_reset: got %h want %h", k, obs, exp_v); end
            rst_n = 1'b1;
            #1;
            exp_v = pk(7'b1000000, 2'b01, 2'b10, 4'h0, 3'b000, 2'b00, 1'b0, ST_FETCH);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL trap%0d_refetch: got %h want %h", k, obs, exp_v); end
            step();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        instr    = 32'h0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        alu_zero = 1'b0;
        test_reset();
        test_r_type();
        test_load();
        test_store();
        test_branch();
        test_jal_lui();
        test_i_type();
        test_traps();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
